shake_pad_inserter: RTL and testbench

//   Streaming message padder in front of the SHAKE absorb datapath. Takes message lanes and a

---
 rtl/shake_pad_if.sv | 34 +++
 rtl/shake_pad_inserter.sv | 171 +++++++++++++++++
 tb/tb_shake_pad_inserter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shake_pad_if.sv
`default_nettype none
// ============================================================================
// Module   : shake_pad_if
// Purpose  : Handshake bundle between a message source/sink and the SHAKE
//            pad inserter (control, input lane stream, padded lane stream).
// Revision : 1.0 - initial release
// ============================================================================
interface shake_pad_if #(
  parameter int W         = 64,
  parameter int LEN_WIDTH = 32
);
  logic                 start;
  logic [LEN_WIDTH-1:0] msg_len;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic                 out_last_lane;
  logic                 out_last_block;

  modport master (
    output start, msg_len, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, out_data, out_last_lane, out_last_block
  );

  modport slave (
    input  start, msg_len, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, out_data, out_last_lane, out_last_block
  );
endinterface
`default_nettype wire

// File: rtl/shake_pad_inserter.sv
`default_nettype none
// ============================================================================
// Module   : shake_pad_inserter
// Purpose  : Streams message lanes into rate-sized blocks with SHAKE padding
//            (DSBYTE after the last message byte, 0x80 in the top byte of
//            the final rate lane). One registered output lane per load.
// Revision : 1.0 - initial release
// ============================================================================
module shake_pad_inserter #(
  parameter int         W          = 64,
  parameter int         RATE_LANES = 17,
  parameter int         LEN_WIDTH  = 32,
  parameter logic [7:0] DSBYTE     = 8'h1F
) (
  input wire        clk,
  input wire        rst,
  shake_pad_if.slave bus
);

  localparam int                   c_LANE_BYTES   = W / 8;
  localparam logic [LEN_WIDTH-1:0] c_LANE_BYTES_L = LEN_WIDTH'(W / 8);
  localparam int                   c_LW           = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [c_LW-1:0]      c_LAST_LANE    = c_LW'(RATE_LANES - 1);
  localparam logic [W-1:0]         c_TOP_BIT      = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [c_LW-1:0]      lane_q, lane_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 out_last_lane_q, out_last_lane_d;
  logic                 out_last_block_q, out_last_block_d;

  logic                 w_load;
  logic                 w_last_idx;
  logic                 w_partial;
  logic                 w_final_wait;
  logic                 w_emit;
  logic                 w_emit_pad;
  logic [W-1:0]         w_emit_data;
  logic [W-1:0]         w_pad_lane;

  assign w_load       = !out_valid_q || bus.out_ready;
  assign w_last_idx   = (lane_q == c_LAST_LANE);
  assign w_partial    = (rem_q < c_LANE_BYTES_L);
  // Final padded lane is sitting in the output register awaiting hand-off.
  assign w_final_wait = out_valid_q && out_last_block_q;

  assign bus.in_ready       = (state_q == S_DATA) && (rem_q != '0) && w_load;
  assign bus.busy           = busy_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_last_lane  = out_last_lane_q;
  assign bus.out_last_block = out_last_block_q;

  // Pad-start lane: keep the remaining message bytes, DSBYTE right after them, zeros above.
  // With rem == 0 this collapses to DSBYTE in byte 0 and ignores the input lane.
  always_comb begin
    w_pad_lane = '0;
    for (int k = 0; k < c_LANE_BYTES; k++) begin
      if (LEN_WIDTH'(k) < rem_q) begin
        w_pad_lane[8*k +: 8] = bus.in_data[8*k +: 8];
      end else if (LEN_WIDTH'(k) == rem_q) begin
        w_pad_lane[8*k +: 8] = DSBYTE;
      end
    end
  end

  // Control FSM and output-register next state.
  always_comb begin
    state_d          = state_q;
    rem_d            = rem_q;
    lane_d           = lane_q;
    busy_d           = busy_q;
    out_valid_d      = out_valid_q;
    out_data_d       = out_data_q;
    out_last_lane_d  = out_last_lane_q;
    out_last_block_d = out_last_block_q;
    w_emit           = 1'b0;
    w_emit_pad       = 1'b0;
    w_emit_data      = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_DATA;
          rem_d   = bus.msg_len;
          lane_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (w_load) begin
          if (rem_q == '0) begin
            w_emit      = 1'b1;
            w_emit_pad  = 1'b1;
            w_emit_data = w_pad_lane;
            state_d     = S_PAD;
          end else if (bus.in_valid) begin
            w_emit = 1'b1;
            if (w_partial) begin
              w_emit_pad  = 1'b1;
              w_emit_data = w_pad_lane;
              rem_d       = '0;
              state_d     = S_PAD;
            end else begin
              w_emit_data = bus.in_data;
              rem_d       = rem_q - c_LANE_BYTES_L;
            end
          end
        end
      end
      S_PAD: begin
        if (w_final_wait) begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else if (w_load) begin
          w_emit      = 1'b1;
          w_emit_pad  = 1'b1;
          w_emit_data = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_load) begin
      out_valid_d = w_emit;
      if (w_emit) begin
        out_data_d       = w_emit_data | ((w_emit_pad && w_last_idx) ? c_TOP_BIT : '0);
        out_last_lane_d  = w_last_idx;
        out_last_block_d = w_emit_pad && w_last_idx;
        lane_d           = w_last_idx ? '0 : lane_q + c_LW'(1);
      end else begin
        out_last_lane_d  = 1'b0;
        out_last_block_d = 1'b0;
      end
    end
  end

  // State and output registers; asynchronous reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      rem_q            <= '0;
      lane_q           <= '0;
      busy_q           <= 1'b0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_last_lane_q  <= 1'b0;
      out_last_block_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      rem_q            <= rem_d;
      lane_q           <= lane_d;
      busy_q           <= busy_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_last_lane_q  <= out_last_lane_d;
      out_last_block_q <= out_last_block_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shake_pad_inserter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shake_pad_inserter
// Purpose  : Scoreboard bench for shake_pad_inserter; directed messages with
//            hand-written lanes plus a byte-level padding reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shake_pad_inserter;
  localparam int W  = 64;
  localparam int RL = 17;
  localparam int LW = 32;

  typedef struct packed {
    logic [63:0] d;
    logic        ll;
    logic        lb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shake_pad_if #(.W(W), .LEN_WIDTH(LW)) bus ();

  shake_pad_inserter #(
    .W(W), .RATE_LANES(RL), .LEN_WIDTH(LW), .DSBYTE(8'h1F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        exp_q[$];
  logic [63:0] in_lanes[$];
  int          total = 0;
  int          bad = 0;
  int          in_acc = 0;
  int          rdy_seen = 0;
  int          popped = 0;
  bit          throttle = 1'b0;
  bit          stall_pend = 1'b0;
  exp_t        held;
  exp_t        cur;
  exp_t        e;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Consumer back-pressure, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    bus.out_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: counts input hand-offs, checks stall stability, pops scoreboard on output hand-off.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) in_acc++;
      if (bus.in_ready) rdy_seen++;
    end
    if (rst || !bus.out_valid) begin
      stall_pend = 1'b0;
    end else begin
      cur = '{bus.out_data, bus.out_last_lane, bus.out_last_block};
      if (stall_pend) chk("stall_hold", cur, held);
      if (bus.out_ready) begin
        stall_pend = 1'b0;
        popped++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_lane: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("lane%0d", popped - 1), cur, e);
        end
      end else begin
        stall_pend = 1'b1;
        held = cur;
      end
    end
  end

  // Reference: classic byte-array padding, then cut into lanes.
  task automatic load_model(input int len);
    logic [7:0]  p[$];
    logic [63:0] lane;
    int          nl;
    for (int i = 0; i < len; i++) p.push_back(8'(i * 13 + 5));
    for (int j = 0; j * 8 < len; j++) begin
      for (int k = 0; k < 8; k++) lane[8*k +: 8] = (j * 8 + k < len) ? p[j*8+k] : 8'hEE;
      in_lanes.push_back(lane);
    end
    p.push_back(8'h1F);
    while (p.size() % 136 != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nl = p.size() / 8;
    for (int j = 0; j < nl; j++) begin
      for (int k = 0; k < 8; k++) lane[8*k +: 8] = p[j*8+k];
      exp_q.push_back('{lane, ((j % 17) == 16), (j == nl - 1)});
    end
  endtask

  // Offer queued input lanes; stop early once stop_at output lanes were seen (0 = never).
  task automatic feed(input int stop_at);
    int  guard;
    bit  acc;
    guard = 0;
    while (in_lanes.size() != 0 && guard < 4000 && !(stop_at != 0 && popped >= stop_at)) begin
      bus.in_valid = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = in_lanes[0];
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) void'(in_lanes.pop_front());
      guard++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    in_acc   = 0;
    rdy_seen = 0;
    popped   = 0;
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.msg_len = LW'(len);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run(input string tag, input int len, input int exp_lanes, input int exp_in);
    int n;
    pulse_start(len);
    n = 0;
    fork
      feed(0);
      begin
        while (bus.busy && n < 5000) begin
          @(negedge clk);
          n++;
        end
      end
    join
    chk({tag, "_busy_drop"}, 66'(bus.busy), 66'(0));
    chk({tag, "_valid_drop"}, 66'(bus.out_valid), 66'(0));
    chk({tag, "_lanes"}, 66'(popped), 66'(exp_lanes));
    chk({tag, "_inputs"}, 66'(in_acc), 66'(exp_in));
    chk({tag, "_sb_empty"}, 66'(exp_q.size()), 66'(0));
    exp_q.delete();
    in_lanes.delete();
  endtask

  task automatic push_len0();
    exp_q.push_back('{64'h1F, 1'b0, 1'b0});
    for (int i = 1; i < 16; i++) exp_q.push_back('{64'h0, 1'b0, 1'b0});
    exp_q.push_back('{64'h8000_0000_0000_0000, 1'b1, 1'b1});
  endtask

  initial begin
    int guard;
    bus.start    = 1'b0;
    bus.msg_len  = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {bus.out_data, bus.out_last_lane, bus.out_last_block}, 66'(0));
    chk("reset_ctl", 66'({bus.busy, bus.out_valid, bus.in_ready}), 66'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty message: pad only, input never requested.
    push_len0();
    run("len0", 0, 17, 0);
    chk("len0_in_ready", 66'(rdy_seen), 66'(0));

    // Three bytes with garbage above them.
    in_lanes.push_back(64'hFFFF_FFFF_FFCC_BBAA);
    exp_q.push_back('{64'h0000_0000_1FCC_BBAA, 1'b0, 1'b0});
    for (int i = 1; i < 16; i++) exp_q.push_back('{64'h0, 1'b0, 1'b0});
    exp_q.push_back('{64'h8000_0000_0000_0000, 1'b1, 1'b1});
    run("len3", 3, 17, 1);

    // Pad start merges with the final-lane bit.
    load_model(135);
    run("len135", 135, 17, 17);

    // Exactly one full block: second block is pure padding.
    load_model(136);
    run("len136", 136, 34, 17);

    // Throttled on both sides.
    throttle = 1'b1;
    load_model(300);
    run("len300", 300, 51, 38);
    throttle = 1'b0;

    // Reset in the middle of a message.
    load_model(200);
    pulse_start(200);
    feed(5);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 66'(bus.busy), 66'(0));
    chk("midrst_valid", 66'(bus.out_valid), 66'(0));
    exp_q.delete();
    in_lanes.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    guard = 0;
    while (guard < 3) begin
      @(posedge clk);
      guard++;
    end
    chk("post_rst_idle", 66'({bus.busy, bus.out_valid}), 66'(0));
    push_len0();
    run("len0_after_rst", 0, 17, 0);
    chk("len0_after_rst_in_ready", 66'(rdy_seen), 66'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
